instr_fetch_unit: RTL

- Upstream stage of the single-cycle datapath.
- Reads a byte-wide, byte-addressed instruction memory and assembles 4 consecutive bytes big-endian into a 32-bit instruction.
- Presents the instruction with its PC over a valid/ready handshake to the execute stage.
- Owns the program counter: sequential +4 stepping, branch/jump redirect, and halt at end of program.

---
 rtl/instr_fetch_unit_pkg.sv | 21 ++
 rtl/instr_fetch_unit_packer.sv | 29 ++
 rtl/instr_fetch_unit.sv | 112 +++++++++++
 3 files changed

// File: rtl/instr_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit: fetch-state encoding,
// PC step size, instruction width and opcode field position.
package instr_fetch_unit_pkg;

  typedef enum logic [1:0] {
    FETCH,
    DRAIN,
    VALID,
    HALT
  } fetch_state_t;

  localparam int PC_STEP    = 4;
  localparam int INSTR_W    = 32;
  localparam int OPCODE_MSB = 31;
  localparam int OPCODE_LSB = 26;

  function automatic logic [OPCODE_MSB-OPCODE_LSB:0] opcode_of(input logic [INSTR_W-1:0] word);
    return word[OPCODE_MSB:OPCODE_LSB];
  endfunction

endpackage

// File: rtl/instr_fetch_unit_packer.sv
// Four byte slots assembled big-endian into one instruction word:
// slot 0 lands in [31:24], slot 3 in [7:0].
module instr_byte_packer
  import instr_fetch_unit_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               clear,
  input  logic               wr_en,
  input  logic [1:0]         slot,
  input  logic [7:0]         wr_data,
  output logic [INSTR_W-1:0] word
);

  logic [7:0] slots [4];

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      for (int i = 0; i < 4; i++) begin
        slots[i] <= '0;
      end
    end else if (wr_en) begin
      slots[slot] <= wr_data;
    end
  end

  assign word = {slots[0], slots[1], slots[2], slots[3]};

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch: reads four bytes from a synchronous byte memory, presents
// the assembled word over valid/ready and owns the program counter.
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter int PC_W   = 8,
  parameter int PC_END = 44
) (
  input  logic               clk,
  input  logic               reset,
  output logic               mem_rd,
  output logic [PC_W-1:0]    mem_addr,
  input  logic [7:0]         mem_rdata,
  output logic [INSTR_W-1:0] instr,
  output logic [PC_W-1:0]    instr_pc,
  output logic               instr_valid,
  input  logic               instr_ready,
  input  logic               redirect,
  input  logic [PC_W-1:0]    redirect_pc,
  output logic               align_err,
  output logic               halted
);

  fetch_state_t    state;
  logic [1:0]      cnt;
  logic [PC_W-1:0] fetch_pc;

  logic            pack_wr;
  logic [1:0]      pack_slot;
  logic [PC_W-1:0] step_pc;
  logic [PC_W:0]   step_pc_wide;
  logic [PC_W-1:0] redirect_aligned;

  // Read data trails the strobe by one cycle, so the slot written is one behind cnt.
  assign pack_wr   = !redirect && ((state == FETCH && cnt != 2'd0) || state == DRAIN);
  assign pack_slot = (state == DRAIN) ? 2'd3 : cnt - 2'd1;

  assign step_pc          = fetch_pc + PC_W'(PC_STEP);
  assign step_pc_wide     = {1'b0, fetch_pc} + (PC_W+1)'(PC_STEP);
  assign redirect_aligned = {redirect_pc[PC_W-1:2], 2'b00};

  assign mem_rd   = !reset && (state == FETCH);
  assign mem_addr = reset ? '0 : fetch_pc + PC_W'(cnt);

  instr_byte_packer u_packer (
    .clk     (clk),
    .reset   (reset),
    .clear   (redirect),
    .wr_en   (pack_wr),
    .slot    (pack_slot),
    .wr_data (mem_rdata),
    .word    (instr)
  );

  // Redirect overrides every state, including a same-cycle handshake in VALID.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= FETCH;
      cnt         <= 2'd0;
      fetch_pc    <= '0;
      instr_pc    <= '0;
      instr_valid <= 1'b0;
      align_err   <= 1'b0;
      halted      <= 1'b0;
    end else if (redirect) begin
      state       <= FETCH;
      cnt         <= 2'd0;
      fetch_pc    <= redirect_aligned;
      instr_valid <= 1'b0;
      halted      <= 1'b0;
      align_err   <= (redirect_pc[1:0] != 2'b00);
    end else begin
      align_err <= 1'b0;
      case (state)
        FETCH: begin
          cnt <= cnt + 2'd1;
          if (cnt == 2'd3) begin
            state <= DRAIN;
          end
        end
        DRAIN: begin
          cnt         <= 2'd0;
          instr_pc    <= fetch_pc;
          instr_valid <= 1'b1;
          state       <= VALID;
        end
        VALID: begin
          if (instr_ready) begin
            fetch_pc    <= step_pc;
            instr_valid <= 1'b0;
            cnt         <= 2'd0;
            // Halt check uses the unwrapped next PC so a wrap past the top also halts.
            if (step_pc_wide >= (PC_W+1)'(PC_END)) begin
              state  <= HALT;
              halted <= 1'b1;
            end else begin
              state <= FETCH;
            end
          end
        end
        HALT: begin
          halted <= 1'b1;
        end
        default: begin
          state <= FETCH;
          cnt   <= 2'd0;
        end
      endcase
    end
  end

endmodule
